// File: rtl/pmp_check_seq.sv
`default_nettype none
// ============================================================================
// Module : pmp_check_seq
// Sequential PMP checker: scans entries group by group and reports a decision.
// Rev    : 1.0
// ============================================================================
module pmp_check_seq #(
    parameter int  NUM_ENTRIES       = 16,
    parameter int  ENTRIES_PER_CYCLE = 4,
    localparam int IDX_W             = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*NUM_ENTRIES-1:0]  pmpcfg,
    input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_size,
    input  logic [1:0]                req_type,
    input  logic [1:0]                req_priv,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_allow,
    output logic                      rsp_hit,
    output logic                      rsp_partial,
    output logic [IDX_W-1:0]          rsp_idx
);
    localparam int NUM_GROUPS = NUM_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d, type_q, type_d, priv_q, priv_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_allow_q, rsp_allow_d;
    logic             rsp_hit_q, rsp_hit_d, rsp_partial_q, rsp_partial_d;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

    // 36-bit range keeps the carry of hi and the 2^35 top of an all-ones NAPOT
    logic [35:0] lo, hi;
    assign lo = {4'b0, addr_q};
    assign hi = lo + (36'd1 << size_q) - 36'd1;

    logic [ENTRIES_PER_CYCLE-1:0] grp_match, grp_full, grp_perm, grp_lock;

    for (genvar j = 0; j < ENTRIES_PER_CYCLE; j++) begin : g_entry
        logic [IDX_W-1:0] e_idx, p_idx;
        logic [7:0]       cfg;
        logic [31:0]      a_cur, a_prev;
        logic [32:0]      napot_mask;
        logic [35:0]      base, top;
        logic             region_ok, perm;
        logic             unused_cfg;

        assign e_idx      = IDX_W'(int'(grp_q) * ENTRIES_PER_CYCLE + j);
        assign p_idx      = (e_idx == '0) ? '0 : e_idx - 1'b1;
        assign cfg        = pmpcfg[8*e_idx +: 8];
        assign a_cur      = pmpaddr[32*e_idx +: 32];
        assign a_prev     = (e_idx == '0) ? 32'd0 : pmpaddr[32*p_idx +: 32];
        // Low t+1 bits set, where t is the count of trailing ones
        assign napot_mask = {1'b0, a_cur} ^ ({1'b0, a_cur} + 33'd1);
        assign unused_cfg = ^cfg[6:5];

        always_comb begin
            base      = '0;
            top       = '0;
            region_ok = 1'b0;
            case (cfg[4:3])
                2'b01: begin
                    base      = {2'b0, a_prev, 2'b0};
                    top       = {2'b0, a_cur, 2'b0};
                    region_ok = (base < top);
                end
                2'b10: begin
                    base      = {2'b0, a_cur, 2'b0};
                    top       = base + 36'd4;
                    region_ok = 1'b1;
                end
                2'b11: begin
                    base      = {1'b0, ({1'b0, a_cur} & ~napot_mask), 2'b0};
                    top       = base + {({1'b0, napot_mask} + 34'd1), 2'b0};
                    region_ok = 1'b1;
                end
                default: ;
            endcase
        end

        always_comb begin
            case (type_q)
                2'b01:   perm = cfg[1];
                2'b10:   perm = cfg[2];
                default: perm = cfg[0];
            endcase
        end

        assign grp_match[j] = region_ok && (lo < top) && (hi >= base);
        assign grp_full[j]  = region_ok && (lo >= base) && (hi < top);
        assign grp_perm[j]  = perm;
        assign grp_lock[j]  = cfg[7];
    end

    logic             sel_any, sel_full, sel_perm, sel_lock;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        sel_any  = 1'b0;
        sel_full = 1'b0;
        sel_perm = 1'b0;
        sel_lock = 1'b0;
        sel_idx  = '0;
        for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
            if (grp_match[j]) begin
                sel_any  = 1'b1;
                sel_full = grp_full[j];
                sel_perm = grp_perm[j];
                sel_lock = grp_lock[j];
                sel_idx  = IDX_W'(int'(grp_q) * ENTRIES_PER_CYCLE + j);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        type_d        = type_q;
        priv_d        = priv_q;
        grp_d         = grp_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_allow_d   = rsp_allow_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_partial_d = rsp_partial_q;
        rsp_idx_d     = rsp_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    type_d  = req_type;
                    priv_d  = req_priv;
                    grp_d   = '0;
                    state_d = (req_size == 2'b11) ? ST_RESP : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sel_any || grp_q == LAST_GRP) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_hit_d     = sel_any;
                    rsp_idx_d     = sel_idx;
                    rsp_partial_d = sel_any && !sel_full;
                    if (!sel_any)
                        rsp_allow_d = (priv_q == 2'b11);
                    else if (sel_full)
                        rsp_allow_d = (!sel_lock && priv_q == 2'b11) || sel_perm;
                    else
                        rsp_allow_d = 1'b0;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            ST_RESP: begin
                // Illegal-size requests arrive here without a response yet
                if (!rsp_valid_q) begin
                    rsp_valid_d   = 1'b1;
                    rsp_allow_d   = 1'b0;
                    rsp_hit_d     = 1'b0;
                    rsp_partial_d = 1'b0;
                    rsp_idx_d     = '0;
                end else if (rsp_ready) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_allow_d   = 1'b0;
                    rsp_hit_d     = 1'b0;
                    rsp_partial_d = 1'b0;
                    rsp_idx_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            type_q        <= '0;
            priv_q        <= '0;
            grp_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_allow_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_partial_q <= 1'b0;
            rsp_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            type_q        <= type_d;
            priv_q        <= priv_d;
            grp_q         <= grp_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_allow_q   <= rsp_allow_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_partial_q <= rsp_partial_d;
            rsp_idx_q     <= rsp_idx_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_allow   = rsp_allow_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_partial = rsp_partial_q;
    assign rsp_idx     = rsp_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pmp_check_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_pmp_check_seq
// Directed and randomized checks of pmp_check_seq against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_pmp_check_seq;
    localparam int N     = 16;
    localparam int EPC   = 4;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8*N-1:0]   pmpcfg;
    logic [32*N-1:0]  pmpaddr;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic [1:0]       req_size = '0;
    logic [1:0]       req_type = '0;
    logic [1:0]       req_priv = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_allow, rsp_hit, rsp_partial;
    logic [IDX_W-1:0] rsp_idx;

    logic [7:0]  cfg_arr  [N];
    logic [31:0] addr_arr [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        pmpcfg  = '0;
        pmpaddr = '0;
        for (int i = 0; i < N; i++) begin
            pmpcfg[8*i +: 8]   = cfg_arr[i];
            pmpaddr[32*i +: 32] = addr_arr[i];
        end
    end

    pmp_check_seq #(.NUM_ENTRIES(N), .ENTRIES_PER_CYCLE(EPC)) dut (
        .clk(clk), .rst(rst), .pmpcfg(pmpcfg), .pmpaddr(pmpaddr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_type(req_type), .req_priv(req_priv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allow(rsp_allow),
        .rsp_hit(rsp_hit), .rsp_partial(rsp_partial), .rsp_idx(rsp_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_arr[i]  = 8'h00;
            addr_arr[i] = 32'h0;
        end
    endtask

    // Reference: walk entries in index order; the first overlapping region decides.
    function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                  input logic [1:0] tp, input logic [1:0] pv,
                                  output logic e_allow, output logic e_hit,
                                  output logic e_part, output int e_idx, output int e_lat);
        longint   lo, hi, base, top;
        int       t;
        bit       ok, m, perm;
        logic [7:0] c;
        m       = (pv == 2'b11);
        e_allow = 1'b0;
        e_hit   = 1'b0;
        e_part  = 1'b0;
        e_idx   = 0;
        e_lat   = N / EPC;
        if (sz == 2'b11) begin
            e_lat = 1;
            return;
        end
        lo = longint'(a);
        hi = lo + (longint'(1) << sz) - 1;
        for (int i = 0; i < N; i++) begin
            c    = cfg_arr[i];
            ok   = 1'b1;
            base = 0;
            top  = 0;
            case (c[4:3])
                2'b00: ok = 1'b0;
                2'b01: begin
                    if (i > 0) base = longint'(addr_arr[i-1]) * 4;
                    top = longint'(addr_arr[i]) * 4;
                    ok  = (base < top);
                end
                2'b10: begin
                    base = longint'(addr_arr[i]) * 4;
                    top  = base + 4;
                end
                default: begin
                    t = 0;
                    while (t < 32 && addr_arr[i][t]) t++;
                    base = (longint'(addr_arr[i]) >> (t + 1)) << (t + 3);
                    top  = base + (longint'(1) << (t + 3));
                end
            endcase
            if (ok && lo < top && hi >= base) begin
                e_hit = 1'b1;
                e_idx = i;
                e_lat = i / EPC + 1;
                if (lo >= base && hi < top) begin
                    perm    = (tp == 2'b01) ? c[1] : (tp == 2'b10) ? c[2] : c[0];
                    e_allow = (m && !c[7]) || perm;
                end else begin
                    e_part  = 1'b1;
                end
                return;
            end
        end
        e_allow = m;
    endfunction

    task automatic do_req(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic [1:0] tp, input logic [1:0] pv, input int hold);
        logic x_allow, x_hit, x_part;
        int   x_idx, x_lat, cyc;
        logic [IDX_W-1:0] xi;
        model(a, sz, tp, pv, x_allow, x_hit, x_part, x_idx, x_lat);
        xi = IDX_W'(x_idx);
        req_addr  = a;
        req_size  = sz;
        req_type  = tp;
        req_priv  = pv;
        req_valid = 1'b1;
        check({tag, ":ready_idle"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ":latency"}, cyc, x_lat);
        check({tag, ":allow"}, rsp_allow, x_allow);
        check({tag, ":hit"}, rsp_hit, x_hit);
        check({tag, ":partial"}, rsp_partial, x_part);
        check({tag, ":idx"}, rsp_idx, xi);
        check({tag, ":ready_busy"}, req_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, ":hold"}, {rsp_valid, rsp_allow, rsp_hit, rsp_partial, rsp_idx, req_ready},
                  {1'b1, x_allow, x_hit, x_part, xi, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ":after_hs"}, {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        clear_cfg();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst:req_ready", req_ready, 1);
        check("rst:rsp_valid", rsp_valid, 0);
        check("rst:rsp_allow", rsp_allow, 0);
        check("rst:rsp_hit", rsp_hit, 0);
        check("rst:rsp_partial", rsp_partial, 0);
        check("rst:rsp_idx", rsp_idx, 0);

        // Reset pulse while scanning an empty config abandons the request
        req_addr = 32'h100; req_size = 2'b10; req_type = 2'b00; req_priv = 2'b11;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("midscan:busy", req_ready, 0);
        rst = 1'b1;
        #2;
        check("midscan:rst_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("midscan:idle", {rsp_valid, req_ready}, 2'b01);
        end

        clear_cfg();
        cfg_arr[5] = 8'h11; addr_arr[5] = 32'h400;
        do_req("na4_read", 32'h1000, 2'b10, 2'b00, 2'b00, 0);
        do_req("na4_write", 32'h1000, 2'b10, 2'b01, 2'b00, 0);

        clear_cfg();
        addr_arr[1] = 32'h800;
        cfg_arr[2]  = 8'h08; addr_arr[2] = 32'hC00;
        cfg_arr[3]  = 8'h1F; addr_arr[3] = 32'h7FF;
        do_req("tor_prio", 32'h2800, 2'b10, 2'b00, 2'b00, 0);
        do_req("napot_below", 32'h1000, 2'b10, 2'b01, 2'b00, 0);
        do_req("napot_above", 32'h3800, 2'b00, 2'b10, 2'b01, 0);

        clear_cfg();
        cfg_arr[0] = 8'h10; addr_arr[0] = 32'h40;
        do_req("partial", 32'h103, 2'b01, 2'b00, 2'b00, 0);

        clear_cfg();
        do_req("nomatch_m", 32'h5000, 2'b10, 2'b01, 2'b11, 0);
        do_req("nomatch_u", 32'h5000, 2'b10, 2'b01, 2'b00, 0);
        cfg_arr[0] = 8'h90; addr_arr[0] = 32'h40;
        do_req("locked_m", 32'h100, 2'b10, 2'b00, 2'b11, 0);
        cfg_arr[0] = 8'h10;
        do_req("unlocked_m", 32'h100, 2'b10, 2'b00, 2'b11, 0);

        clear_cfg();
        cfg_arr[0] = 8'h19; addr_arr[0] = 32'hFFFF_FFFF;
        do_req("napot_all", 32'hFFFF_FFFC, 2'b10, 2'b00, 2'b00, 0);
        do_req("backpressure", 32'h100, 2'b10, 2'b00, 2'b11, 5);
        do_req("illegal_size", 32'h100, 2'b11, 2'b00, 2'b11, 2);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                cfg_arr[i]  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                addr_arr[i] = $urandom_range(0, 32'h600);
            end
            if (it % 7 == 0) begin
                cfg_arr[15] = 8'h1D; addr_arr[15] = 32'hFFFF_FFFF;
            end
            do_req("random", $urandom_range(0, 32'h1900), 2'($urandom_range(0, 3)),
                   2'($urandom), 2'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
